// File: rtl/cla_sum_accumulator.sv
// Accumulates streamed 33-bit {co_cla, s_cla} CLA results into a wide sum over a counted job.
// Optional define CLA_ACC_SAT_EN: clamp acc_sum to all-ones on overflow instead of wrapping.
module cla_sum_accumulator #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] s_cla,
    input  logic              co_cla,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_sum,
    output logic              acc_ovf,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] num_lat;
    logic [ACC_W:0]   beat_ext;
    logic [ACC_W:0]   sum_raw;
    logic [ACC_W:0]   sum_upd;

    // Returns {carry, next_sum}; saturating build pins the sum at all-ones once a carry escapes.
    function automatic logic [ACC_W:0] acc_update(input logic [ACC_W:0] raw);
`ifdef CLA_ACC_SAT_EN
        return {raw[ACC_W], raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0]};
`else
        return raw;
`endif
    endfunction

    always_comb begin
        beat_ext = (ACC_W+1)'({co_cla, s_cla});
        sum_raw  = {1'b0, acc_sum} + beat_ext;
        sum_upd  = acc_update(sum_raw);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            acc_sum   <= '0;
            acc_ovf   <= 1'b0;
            word_cnt  <= '0;
            num_lat   <= '0;
        end else if (clear) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            acc_sum   <= '0;
            acc_ovf   <= 1'b0;
            word_cnt  <= '0;
            num_lat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_sum  <= '0;
                        acc_ovf  <= 1'b0;
                        word_cnt <= '0;
                        num_lat  <= num_words;
                        if (num_words != '0) begin
                            state    <= ACC;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc_sum  <= sum_upd[ACC_W-1:0];
                        acc_ovf  <= acc_ovf | sum_upd[ACC_W];
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == num_lat - 1'b1) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Result fields stay frozen here and through the following IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
